// File: rtl/imem_loader_pkg.sv
// Shared widths, loader state encoding and per-state output flags for the imem boot loader.
package imem_loader_pkg;

   localparam int unsigned IWIDTH_DFLT   = 32;
   localparam int unsigned PC_WIDTH_DFLT = 32;
   localparam int unsigned BYTE_WIDTH    = 8;

   typedef enum logic [2:0] {
      IlIdle  = 3'd0,
      IlLoad  = 3'd1,
      IlWrite = 3'd2,
      IlDone  = 3'd3,
      IlError = 3'd4
   } il_state_e;

   typedef struct packed {
      logic ready;
      logic busy;
      logic done;
      logic error;
      logic core_ce;
   } il_flags_t;

   // Status flags for a state; registered by the FSM from the next state.
   function automatic il_flags_t state_flags(input il_state_e s);
      il_flags_t f;
      f = '0;
      case (s)
         IlLoad: begin
            f.ready = 1'b1;
            f.busy  = 1'b1;
         end
         IlWrite: f.busy = 1'b1;
         IlDone: begin
            f.done    = 1'b1;
            f.core_ce = 1'b1;
         end
         IlError: f.error = 1'b1;
         default: f = '0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/il_word_pack.sv
// Big-endian byte packer: shifts bytes into a word and flags the byte that completes it.
module il_word_pack
   import imem_loader_pkg::*;
#(
   parameter int unsigned IWIDTH = IWIDTH_DFLT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  shift,
   input  logic [BYTE_WIDTH-1:0] din,
   output logic [IWIDTH-1:0]     word,
   output logic                  word_full
);

   localparam int unsigned BytesPerWord = IWIDTH / BYTE_WIDTH;
   localparam logic [1:0]  LastByte     = 2'(BytesPerWord - 1);

   logic [IWIDTH-1:0] shift_q;
   logic [1:0]        byte_cnt_q;

   // Word including the byte on the input this cycle, so a write can follow the last handshake.
   assign word      = {shift_q[IWIDTH-BYTE_WIDTH-1:0], din};
   assign word_full = shift && (byte_cnt_q == LastByte);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q    <= '0;
         byte_cnt_q <= '0;
      end else if (clr) begin
         shift_q    <= '0;
         byte_cnt_q <= '0;
      end else if (shift) begin
         shift_q    <= word;
         byte_cnt_q <= byte_cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader; stalls the core until the whole program is written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned IWIDTH    = IWIDTH_DFLT,
   parameter int unsigned PC_WIDTH  = PC_WIDTH_DFLT,
   parameter int unsigned LEN_WIDTH = 12,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned TIMEOUT   = 65535
) (
   input  logic                  il_clk,
   input  logic                  il_rst,
   input  logic                  il_i_start,
   input  logic [LEN_WIDTH-1:0]  il_i_length,
   input  logic                  il_i_valid,
   input  logic [BYTE_WIDTH-1:0] il_i_byte,
   output logic                  il_o_ready,
   output logic                  il_o_wr_en,
   output logic [PC_WIDTH-1:0]   il_o_wr_addr,
   output logic [IWIDTH-1:0]     il_o_wr_data,
   output logic                  il_o_busy,
   output logic                  il_o_done,
   output logic                  il_o_error,
   output logic                  il_o_core_ce
);

   localparam int unsigned   IdleW    = $clog2(TIMEOUT + 1);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);
   localparam logic [PC_WIDTH-1:0] Base = PC_WIDTH'(BASE_ADDR);

   il_state_e            state_q, state_d;
   il_flags_t            flags_q;
   logic                 wr_en_q;
   logic [PC_WIDTH-1:0]  wr_addr_q, addr_q;
   logic [IWIDTH-1:0]    wr_data_q;
   logic [LEN_WIDTH-1:0] length_q, word_cnt_q, word_cnt_inc;
   logic [IdleW-1:0]     idle_cnt_q;

   logic              hs, start_acc, word_full;
   logic [IWIDTH-1:0] packed_word;

   // ready is registered, so the handshake has no combinational path to any output.
   assign hs           = il_i_valid && flags_q.ready;
   assign start_acc    = il_i_start &&
                         (state_q == IlIdle || state_q == IlDone || state_q == IlError);
   assign word_cnt_inc = word_cnt_q + LEN_WIDTH'(1);

   il_word_pack #(
      .IWIDTH(IWIDTH)
   ) u_pack (
      .clk      (il_clk),
      .rst      (il_rst),
      .clr      (start_acc),
      .shift    (hs),
      .din      (il_i_byte),
      .word     (packed_word),
      .word_full(word_full)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IlIdle, IlDone, IlError: begin
            if (il_i_start) begin
               state_d = (il_i_length == '0) ? IlDone : IlLoad;
            end
         end
         IlLoad: begin
            if (word_full) begin
               state_d = IlWrite;
            end else if (!hs && idle_cnt_q == IdleLast) begin
               state_d = IlError;
            end
         end
         IlWrite: state_d = (word_cnt_inc == length_q) ? IlDone : IlLoad;
         default: state_d = IlIdle;
      endcase
   end

   always_ff @(posedge il_clk or posedge il_rst) begin
      if (il_rst) begin
         state_q    <= IlIdle;
         flags_q    <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         addr_q     <= '0;
         length_q   <= '0;
         word_cnt_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= state_flags(state_d);
         wr_en_q <= (state_d == IlWrite);

         if (start_acc) begin
            length_q   <= il_i_length;
            word_cnt_q <= '0;
            addr_q     <= Base;
            idle_cnt_q <= '0;
         end

         if (state_q == IlLoad) begin
            idle_cnt_q <= hs ? '0 : idle_cnt_q + IdleW'(1);
         end

         // Address and data are latched once per word and held until the next word.
         if (word_full) begin
            wr_addr_q <= addr_q;
            wr_data_q <= packed_word;
         end

         if (state_q == IlWrite) begin
            addr_q     <= addr_q + PC_WIDTH'(4);
            word_cnt_q <= word_cnt_inc;
            idle_cnt_q <= '0;
         end
      end
   end

   assign il_o_ready   = flags_q.ready;
   assign il_o_busy    = flags_q.busy;
   assign il_o_done    = flags_q.done;
   assign il_o_error   = flags_q.error;
   assign il_o_core_ce = flags_q.core_ce;
   assign il_o_wr_en   = wr_en_q;
   assign il_o_wr_addr = wr_addr_q;
   assign il_o_wr_data = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus, checked at wr_en.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] length = '0;
   logic        valid = 1'b0;
   logic [7:0]  din = '0;
   logic        ready, wr_en, busy, done, error, core_ce;
   logic [31:0] wr_addr, wr_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_wr_cyc = 0;
   int wr_total = 0;
   logic [63:0] sb[$];

   imem_loader #(
      .IWIDTH   (32),
      .PC_WIDTH (32),
      .LEN_WIDTH(12),
      .BASE_ADDR(0),
      .TIMEOUT  (16)
   ) dut (
      .il_clk      (clk),
      .il_rst      (rst),
      .il_i_start  (start),
      .il_i_length (length),
      .il_i_valid  (valid),
      .il_i_byte   (din),
      .il_o_ready  (ready),
      .il_o_wr_en  (wr_en),
      .il_o_wr_addr(wr_addr),
      .il_o_wr_data(wr_data),
      .il_o_busy   (busy),
      .il_o_done   (done),
      .il_o_error  (error),
      .il_o_core_ce(core_ce)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Write monitor plus per-cycle invariants.
   always @(negedge clk) begin
      logic [63:0] e;
      if (wr_en) begin
         wr_total++;
         last_wr_cyc = cyc;
         chk("ready_in_write", {63'd0, ready}, 64'd0);
         if (sb.size() == 0) begin
            chk("unexpected_wr", {wr_addr, wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("wr_addr_data", {wr_addr, wr_data}, e);
         end
      end
      chk("flags_excl", {63'd0, ($countones({done, error, busy}) <= 1)}, 64'd1);
      chk("core_ce_eq_done", {63'd0, core_ce}, {63'd0, done});
   end

   task automatic pulse_start(input logic [11:0] len);
      start  = 1'b1;
      length = len;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      valid = 1'b1;
      din   = b;
      @(negedge clk);
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("byte_hs_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input int gap);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] t;
         t = w >> (8 * (3 - i));
         if (i == 3) sb.push_back({addr, w});
         send_byte(t[7:0]);
         if (gap > 0 && i < 3) begin
            valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {63'd0, done}, 64'd1);
   endtask

   initial begin
      int wr_before;
      #12;
      chk("rst_outputs", {ready, wr_en, busy, done, error, core_ce, wr_addr, wr_data}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_ready", {62'd0, ready, busy}, 64'd0);
      @(posedge clk);
      #1;

      // 1: two words, valid held high
      pulse_start(12'd2);
      @(negedge clk);
      chk("load_ready", {61'd0, ready, busy, core_ce}, 64'b110);
      @(posedge clk);
      #1;
      send_word(32'h2008_0005, 32'h0, 0);
      send_word(32'h8C09_0004, 32'h4, 0);
      valid = 1'b0;
      wait_done("t1_done");
      chk("t1_done_latency", 64'(cyc - last_wr_cyc), 64'd1);
      chk("t1_core_ce", {63'd0, core_ce}, 64'd1);
      chk("t1_hold", {wr_addr, wr_data}, 64'h0000_0004_8C09_0004);
      chk("t1_sb_empty", 64'(sb.size()), 64'd0);

      // 2: gapped stream, valid high through WRITE
      @(posedge clk);
      #1;
      pulse_start(12'd2);
      @(negedge clk);
      chk("t2_done_falls", {62'd0, done, core_ce}, 64'd0);
      @(posedge clk);
      #1;
      send_word(32'h2008_0005, 32'h0, 3);
      send_word(32'h8C09_0004, 32'h4, 3);
      valid = 1'b0;
      wait_done("t2_done");
      chk("t2_sb_empty", 64'(sb.size()), 64'd0);

      // 3: zero-length load
      wr_before = wr_total;
      @(posedge clk);
      #1;
      pulse_start(12'd0);
      @(negedge clk);
      chk("t3_done", {62'd0, done, core_ce}, 64'b11);
      repeat (3) @(negedge clk);
      chk("t3_no_wr", 64'(wr_total), 64'(wr_before));

      // 4: partial word times out, then a clean reload
      @(posedge clk);
      #1;
      wr_before = wr_total;
      pulse_start(12'd1);
      send_byte(8'hDE);
      send_byte(8'hAD);
      valid = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("t4_no_err_early", {63'd0, error}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("t4_error", {61'd0, error, core_ce, busy}, 64'b100);
      chk("t4_no_wr", 64'(wr_total), 64'(wr_before));
      @(posedge clk);
      #1;
      pulse_start(12'd1);
      @(negedge clk);
      chk("t4_err_clear", {62'd0, error, busy}, 64'b01);
      @(posedge clk);
      #1;
      send_word(32'hDEAD_BEEF, 32'h0, 1);
      valid = 1'b0;
      wait_done("t4_done");
      chk("t4_sb_empty", 64'(sb.size()), 64'd0);

      // 5: reload from DONE stalls the core first
      @(posedge clk);
      #1;
      pulse_start(12'd1);
      @(negedge clk);
      chk("t5_stall", {61'd0, core_ce, done, busy}, 64'b001);
      @(posedge clk);
      #1;
      send_word(32'h1234_5678, 32'h0, 0);
      valid = 1'b0;
      wait_done("t5_done");
      chk("t5_sb_empty", 64'(sb.size()), 64'd0);

      // 6: asynchronous reset after 5 of 8 bytes
      @(posedge clk);
      #1;
      pulse_start(12'd2);
      send_word(32'hCAFE_F00D, 32'h0, 0);
      send_byte(8'h11);
      valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("t6_async_rst", {ready, wr_en, busy, done, error, core_ce, wr_addr, wr_data}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_idle", {61'd0, ready, busy, wr_en}, 64'd0);
      chk("t6_sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
